control_subcmd_readarea: RTL and testbench

Reads a rectangular pixel region back out of frame-buffer RAM, one byte at a time, and streams it to the command-response transmitter over a valid/ready byte interface. It is the read-side counterpart of the fill-area subcommand. It drives the same row/column/pixel address bus and the same toggle-based ram_access_start strobe. It also uses the same done/ack completion handshake toward the command controller.

---
 rtl/control_subcmd_readarea_pkg.sv | 25 ++
 rtl/control_subcmd_readarea_rect_scan_counter.sv | 88 ++++++++
 rtl/control_subcmd_readarea.sv | 168 ++++++++++++++++
 tb/tb_control_subcmd_readarea.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_subcmd_readarea_pkg.sv
// Types and address widths shared by the frame-buffer area subcommands
// (fill-area writes a rectangle, read-area streams one back out).
package control_subcmd_readarea_pkg;

  localparam int unsigned DEF_PIXEL_WIDTH     = 64;
  localparam int unsigned DEF_PIXEL_HEIGHT    = 32;
  localparam int unsigned DEF_BYTES_PER_PIXEL = 2;

  // Width of a field that counts 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CW = $clog2(DEF_PIXEL_WIDTH);
  localparam int unsigned RW = $clog2(DEF_PIXEL_HEIGHT);
  localparam int unsigned PW = clog2_min1(DEF_BYTES_PER_PIXEL);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_PRESENT   = 2'd2,
    ST_DONE_WAIT = 2'd3
  } read_state_e;

endpackage

// File: rtl/control_subcmd_readarea_rect_scan_counter.sv
// Descending row/column/pixel iterator over a rectangle: rows from bottom to
// top, columns right to left, pixel bytes high to low. last marks (y1,x1,0).
module rect_scan_counter
  import control_subcmd_readarea_pkg::*;
#(
  parameter int unsigned COL_W = CW,
  parameter int unsigned ROW_W = RW,
  parameter int unsigned PIX_W = PW,
  parameter int unsigned BPP   = DEF_BYTES_PER_PIXEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [COL_W-1:0] x1,
  input  logic [ROW_W-1:0] y1,
  input  logic [COL_W-1:0] width,
  input  logic [ROW_W-1:0] height,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] column,
  output logic [PIX_W-1:0] pixel,
  output logic             last
);

  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(BPP - 1);

  logic [COL_W-1:0] x_lo_q, x_lo_d;
  logic [COL_W-1:0] x_hi_q, x_hi_d;
  logic [ROW_W-1:0] y_lo_q, y_lo_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] column_q, column_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;

  always_comb begin
    x_lo_d   = x_lo_q;
    x_hi_d   = x_hi_q;
    y_lo_d   = y_lo_q;
    row_d    = row_q;
    column_d = column_q;
    pixel_d  = pixel_q;
    if (load) begin
      // x1+width wraps to 0 when the region touches the right edge, so
      // subtracting one lands back on the last column.
      x_lo_d   = x1;
      y_lo_d   = y1;
      x_hi_d   = x1 + width - COL_W'(1);
      row_d    = y1 + height - ROW_W'(1);
      column_d = x1 + width - COL_W'(1);
      pixel_d  = PIX_MAX;
    end else if (step) begin
      if (pixel_q != '0) begin
        pixel_d = pixel_q - PIX_W'(1);
      end else begin
        pixel_d = PIX_MAX;
        if (column_q == x_lo_q) begin
          column_d = x_hi_q;
          row_d    = row_q - ROW_W'(1);
        end else begin
          column_d = column_q - COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_lo_q   <= '0;
      x_hi_q   <= '0;
      y_lo_q   <= '0;
      row_q    <= '0;
      column_q <= '0;
      pixel_q  <= '0;
    end else begin
      x_lo_q   <= x_lo_d;
      x_hi_q   <= x_hi_d;
      y_lo_q   <= y_lo_d;
      row_q    <= row_d;
      column_q <= column_d;
      pixel_q  <= pixel_d;
    end
  end

  assign row    = row_q;
  assign column = column_q;
  assign pixel  = pixel_q;
  assign last   = (row_q == y_lo_q) && (column_q == x_lo_q) && (pixel_q == '0);

endmodule

// File: rtl/control_subcmd_readarea.sv
// Read-area subcommand: walks a frame-buffer rectangle and streams each RAM
// byte to the response transmitter over a valid/ready byte interface.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | waiting for enable; empty regions finish immediately
// ST_WAIT_DATA | RAM access toggled, latency counter running down
// ST_PRESENT   | byte_out valid, held until byte_ready
// ST_DONE_WAIT | done raised, waiting for controller ack
module control_subcmd_readarea
  import control_subcmd_readarea_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
  parameter int unsigned PIXEL_HEIGHT     = DEF_PIXEL_HEIGHT,
  parameter int unsigned BYTES_PER_PIXEL  = DEF_BYTES_PER_PIXEL,
  parameter int unsigned RAM_READ_LATENCY = 1,
  localparam int unsigned COL_W = $clog2(PIXEL_WIDTH),
  localparam int unsigned ROW_W = $clog2(PIXEL_HEIGHT),
  localparam int unsigned PIX_W = clog2_min1(BYTES_PER_PIXEL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ack,
  input  logic [COL_W-1:0] x1,
  input  logic [ROW_W-1:0] y1,
  input  logic [COL_W-1:0] width,
  input  logic [ROW_W-1:0] height,
  input  logic [7:0]       ram_data_in,
  input  logic             byte_ready,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] column,
  output logic [PIX_W-1:0] pixel,
  output logic             ram_read_enable,
  output logic             ram_access_start,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      LAT_W    = clog2_min1(RAM_READ_LATENCY);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_READ_LATENCY - 1);

  read_state_e      state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             ram_read_enable_q, ram_read_enable_d;
  logic             ram_access_start_q, ram_access_start_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic scan_load;
  logic scan_step;
  logic scan_last;

  rect_scan_counter #(
    .COL_W (COL_W),
    .ROW_W (ROW_W),
    .PIX_W (PIX_W),
    .BPP   (BYTES_PER_PIXEL)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .load   (scan_load),
    .step   (scan_step),
    .x1     (x1),
    .y1     (y1),
    .width  (width),
    .height (height),
    .row    (row),
    .column (column),
    .pixel  (pixel),
    .last   (scan_last)
  );

  always_comb begin
    state_d            = state_q;
    lat_d              = lat_q;
    ram_read_enable_d  = ram_read_enable_q;
    ram_access_start_d = ram_access_start_q;
    byte_out_d         = byte_out_q;
    byte_valid_d       = byte_valid_q;
    done_d             = done_q;
    scan_load          = 1'b0;
    scan_step          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if ((width == '0) || (height == '0)) begin
            done_d  = 1'b1;
            state_d = ST_DONE_WAIT;
          end else begin
            scan_load          = 1'b1;
            ram_read_enable_d  = 1'b1;
            ram_access_start_d = ~ram_access_start_q;
            lat_d              = LAT_INIT;
            state_d            = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (lat_q == '0) begin
          byte_out_d   = ram_data_in;
          byte_valid_d = 1'b1;
          state_d      = ST_PRESENT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_PRESENT: begin
        if (byte_valid_q && byte_ready) begin
          byte_valid_d = 1'b0;
          if (scan_last) begin
            ram_read_enable_d = 1'b0;
            done_d            = 1'b1;
            state_d           = ST_DONE_WAIT;
          end else begin
            // Address advance and the next RAM strobe share this edge.
            scan_step          = 1'b1;
            ram_access_start_d = ~ram_access_start_q;
            lat_d              = LAT_INIT;
            state_d            = ST_WAIT_DATA;
          end
        end
      end
      ST_DONE_WAIT: begin
        if (ack) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      lat_q              <= '0;
      ram_read_enable_q  <= 1'b0;
      ram_access_start_q <= 1'b0;
      byte_out_q         <= '0;
      byte_valid_q       <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      lat_q              <= lat_d;
      ram_read_enable_q  <= ram_read_enable_d;
      ram_access_start_q <= ram_access_start_d;
      byte_out_q         <= byte_out_d;
      byte_valid_q       <= byte_valid_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
    end
  end

  assign ram_read_enable  = ram_read_enable_q;
  assign ram_access_start = ram_access_start_q;
  assign byte_out         = byte_out_q;
  assign byte_valid       = byte_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_control_subcmd_readarea.sv
// Directed bench for control_subcmd_readarea: one latency-1 instance with a
// scoreboard of expected (address, data) per byte, plus a latency-3 instance.
module tb_control_subcmd_readarea;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- latency-1 instance ----------------
  logic       enable1 = 1'b0, ack1 = 1'b0, byte_ready1 = 1'b1;
  logic [5:0] x1_1 = '0, width1 = '0;
  logic [4:0] y1_1 = '0, height1 = '0;
  logic [7:0] ram_data1;
  logic [4:0] row1;
  logic [5:0] col1;
  logic [0:0] pix1;
  logic       rre1, start1, bv1, busy1, done1;
  logic [7:0] bout1;

  control_subcmd_readarea #(.RAM_READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .ack(ack1),
    .x1(x1_1), .y1(y1_1), .width(width1), .height(height1),
    .ram_data_in(ram_data1), .byte_ready(byte_ready1),
    .row(row1), .column(col1), .pixel(pix1),
    .ram_read_enable(rre1), .ram_access_start(start1),
    .byte_out(bout1), .byte_valid(bv1), .busy(busy1), .done(done1));

  // ---------------- latency-3 instance ----------------
  logic       enable3 = 1'b0, ack3 = 1'b0, byte_ready3 = 1'b1;
  logic [5:0] x1_3 = '0, width3 = '0;
  logic [4:0] y1_3 = '0, height3 = '0;
  logic [7:0] ram_data3;
  logic [4:0] row3;
  logic [5:0] col3;
  logic [0:0] pix3;
  logic       rre3, start3, bv3, busy3, done3;
  logic [7:0] bout3;

  control_subcmd_readarea #(.RAM_READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .ack(ack3),
    .x1(x1_3), .y1(y1_3), .width(width3), .height(height3),
    .ram_data_in(ram_data3), .byte_ready(byte_ready3),
    .row(row3), .column(col3), .pixel(pix3),
    .ram_read_enable(rre3), .ram_access_start(start3),
    .byte_out(bout3), .byte_valid(bv3), .busy(busy3), .done(done3));

  // RAM content model
  function automatic logic [7:0] ram_f(input int r, input int c, input int p);
    return 8'(r * 29 + c * 7 + p * 3 + 1);
  endfunction

  // RAM models: data is valid only in the cycle the latency says it is.
  logic start1_prev = 1'b0;
  logic start3_prev = 1'b0, tog3_d1 = 1'b0, tog3_d2 = 1'b0;
  int   tog1 = 0, tog3 = 0;
  always @(posedge clk) begin
    if (start1 !== start1_prev) tog1++;
    if (start3 !== start3_prev) tog3++;
    start1_prev <= start1;
    start3_prev <= start3;
    tog3_d1     <= start3 ^ start3_prev;
    tog3_d2     <= tog3_d1;
  end
  assign ram_data1 = (start1 !== start1_prev) ? ram_f(row1, col1, pix1) : 8'hEE;
  assign ram_data3 = tog3_d2 ? ram_f(row3, col3, pix3) : 8'hEE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int r;
    int c;
    int p;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  task automatic push_region(input int x, input int y, input int w, input int h);
    exp_t e;
    for (int r = y + h - 1; r >= y; r--)
      for (int c = x + w - 1; c >= x; c--)
        for (int p = 1; p >= 0; p--) begin
          e.r = r; e.c = c; e.p = p; e.d = ram_f(r, c, p);
          sb.push_back(e);
        end
  endtask

  // Handshake monitor for the latency-1 instance.
  int hs_count = 0, bv_cycles = 0, first_hs = -1, last_hs = -1;
  always @(negedge clk) begin
    if (!reset && bv1) begin
      bv_cycles++;
      if (byte_ready1) begin
        exp_t e;
        hs_count++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (sb.size() == 0) begin
          check("sb_unexpected_byte", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("hs_data", bout1, e.d);
          check("hs_addr", {row1, col1, pix1}, {5'(e.r), 6'(e.c), 1'(e.p)});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(input string tag);
    for (int i = 0; i < 200 && !done1; i++) step();
    check(tag, done1, 1'b1);
  endtask

  task automatic start1_cmd(input int x, input int y, input int w, input int h);
    x1_1 = 6'(x); y1_1 = 5'(y); width1 = 6'(w); height1 = 5'(h);
    enable1 = 1'b1;
    step();
    enable1 = 1'b0;
  endtask

  task automatic ack1_pulse();
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
  endtask

  initial begin
    int hs_base, tog_base, bv_base, done_cyc;

    // ---- reset values ----
    #1 reset = 1'b1;
    step(); step();
    check("reset_outputs1", {row1, col1, pix1, rre1, start1, bout1, bv1, busy1, done1}, 32'd0);
    check("reset_outputs3", {row3, col3, pix3, rre3, start3, bout3, bv3, busy3, done3}, 32'd0);
    reset = 1'b0;
    step();

    // ---- 2x2 region, byte_ready high ----
    hs_base = hs_count; tog_base = tog1; first_hs = -1;
    push_region(3, 5, 2, 2);
    start1_cmd(3, 5, 2, 2);
    check("busy_after_start", busy1, 1'b1);
    check("rre_after_start", rre1, 1'b1);
    wait_done1("t1_done_timeout");
    done_cyc = cyc;
    check("t1_bytes", 32'(hs_count - hs_base), 32'd8);
    check("t1_toggles", 32'(tog1 - tog_base), 32'd8);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_done_latency", 32'(done_cyc - last_hs), 32'd1);
    check("t1_throughput", 32'(last_hs - first_hs), 32'd14);
    check("t1_rre_off", rre1, 1'b0);
    ack1_pulse();
    check("t1_done_cleared", {done1, busy1}, 2'b00);

    // ---- same region, stall 5 cycles on the third byte ----
    hs_base = hs_count; tog_base = tog1;
    push_region(3, 5, 2, 2);
    start1_cmd(3, 5, 2, 2);
    for (int i = 0; i < 100 && hs_count < hs_base + 2; i++) step();
    byte_ready1 = 1'b0;
    for (int i = 0; i < 20 && !bv1; i++) step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bv1, 1'b1);
      check("stall_byte", bout1, ram_f(6, 3, 1));
      check("stall_addr", {row1, col1, pix1}, {5'd6, 6'd3, 1'd1});
      check("stall_start", start1, 1'b1);
      check("stall_toggles", 32'(tog1 - tog_base), 32'd3);
      step();
    end
    byte_ready1 = 1'b1;
    wait_done1("t2_done_timeout");
    check("t2_bytes", 32'(hs_count - hs_base), 32'd8);
    check("t2_toggles", 32'(tog1 - tog_base), 32'd8);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    ack1_pulse();

    // ---- empty region ----
    tog_base = tog1; bv_base = bv_cycles;
    start1_cmd(7, 2, 0, 3);
    check("empty_done", {done1, busy1, bv1, rre1}, 4'b1100);
    step(); step();
    check("empty_toggles", 32'(tog1 - tog_base), 32'd0);
    check("empty_no_valid", 32'(bv_cycles - bv_base), 32'd0);
    ack1_pulse();
    check("empty_ack", done1, 1'b0);

    // ---- reset during the fourth byte's WAIT_DATA ----
    hs_base = hs_count;
    push_region(3, 5, 2, 2);
    start1_cmd(3, 5, 2, 2);
    for (int i = 0; i < 100 && hs_count < hs_base + 3; i++) step();
    check("pre_reset_state", {rre1, bv1, busy1}, 3'b101);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {row1, col1, pix1, rre1, start1, bout1, bv1, busy1, done1}, 32'd0);
    sb.delete();
    step();
    reset = 1'b0;
    step();
    hs_base = hs_count; tog_base = tog1;
    push_region(10, 2, 1, 1);
    start1_cmd(10, 2, 1, 1);
    wait_done1("t4_done_timeout");
    check("t4_bytes", 32'(hs_count - hs_base), 32'd2);
    check("t4_toggles", 32'(tog1 - tog_base), 32'd2);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // ---- done held without ack, enable ignored ----
    tog_base = tog1;
    for (int i = 0; i < 10; i++) begin
      enable1 = 1'(i);
      step();
      check("hold_done", {done1, busy1}, 2'b11);
    end
    check("hold_toggles", 32'(tog1 - tog_base), 32'd0);
    enable1 = 1'b1;
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    enable1 = 1'b0;
    check("ack_with_enable", {done1, busy1}, 2'b00);
    step();
    check("ack_enable_ignored", {busy1, 32'(tog1 - tog_base)}, 33'd0);
    hs_base = hs_count;
    push_region(0, 0, 1, 1);
    start1_cmd(0, 0, 1, 1);
    check("restart_busy", busy1, 1'b1);
    wait_done1("t5_done_timeout");
    check("t5_bytes", 32'(hs_count - hs_base), 32'd2);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    ack1_pulse();

    // ---- latency 3, 1x1 region at the far corner ----
    x1_3 = 6'd63; y1_3 = 5'd31; width3 = 6'd1; height3 = 5'd1;
    enable3 = 1'b1;
    step();
    enable3 = 1'b0;
    check("l3_toggle", {rre3, start3, bv3}, 3'b110);
    step();
    check("l3_valid_e1", bv3, 1'b0);
    step();
    check("l3_valid_e2", bv3, 1'b0);
    step();
    check("l3_valid_e3", bv3, 1'b1);
    check("l3_byte0", bout3, ram_f(31, 63, 1));
    check("l3_addr0", {row3, col3, pix3}, {5'd31, 6'd63, 1'd1});
    step();
    check("l3_after_hs", {bv3, start3}, 2'b00);
    step(); step();
    check("l3_valid_e6", bv3, 1'b0);
    step();
    check("l3_valid_e7", bv3, 1'b1);
    check("l3_byte1", bout3, ram_f(31, 63, 0));
    check("l3_addr1", {row3, col3, pix3}, {5'd31, 6'd63, 1'd0});
    step();
    check("l3_done", {done3, bv3, rre3}, 3'b100);
    check("l3_toggles", 32'(tog3), 32'd2);
    ack3 = 1'b1;
    step();
    ack3 = 1'b0;
    check("l3_ack", {done3, busy3}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
